// File: rtl/mmcm_drp_reconfig_if.sv
// User, ROM, DRP and MMCM control signals of the MMCM reconfiguration
// controller; master is the controller side.
interface mmcm_drp_reconfig_if #(
  parameter int CW = 1,
  parameter int AW = 6
);
  logic          SEN;
  logic [CW-1:0] SADDR;
  logic          BUSY;
  logic          SRDY;
  logic          ERR;
  logic [AW-1:0] ROM_ADDR;
  logic [38:0]   ROM_DATA;
  logic [6:0]    DADDR;
  logic [15:0]   DI;
  logic [15:0]   DO;
  logic          DEN;
  logic          DWE;
  logic          DRDY;
  logic          MMCM_RST;
  logic          LOCKED;

  modport master (
    input  SEN, SADDR, ROM_DATA, DO, DRDY, LOCKED,
    output BUSY, SRDY, ERR, ROM_ADDR,
    output DADDR, DI, DEN, DWE, MMCM_RST
  );

  modport slave (
    output SEN, SADDR, ROM_DATA, DO, DRDY, LOCKED,
    input  BUSY, SRDY, ERR, ROM_ADDR,
    input  DADDR, DI, DEN, DWE, MMCM_RST
  );
endinterface

// File: rtl/mmcm_drp_reconfig.sv
// MMCME2 DRP reconfiguration: read-modify-write of one stored config
// with the MMCM held in reset, then wait for lock.
module mmcm_drp_reconfig #(
  parameter int NUM_CFG      = 2,
  parameter int NUM_REG      = 23,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic DCLK,
  input  logic RST_N,
  mmcm_drp_reconfig_if.master bus
);
  localparam int CW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int NT = NUM_CFG * NUM_REG;
  localparam int AW = (NT > 1) ? $clog2(NT) : 1;
  localparam int IW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam int TM = (DRDY_TIMEOUT > LOCK_TIMEOUT) ?
                      DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW = $clog2(TM + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT, S_FETCH, S_READ,
    S_WAIT_RD, S_WRITE, S_WAIT_WR, S_RELEASE,
    S_WAIT_LOCK, S_DONE, S_ABORT
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [15:0]   mask_q, mask_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   di_q, di_d;
  logic          bad_q, bad_d;
  logic [CW-1:0] saddr;
  logic          last;
  logic          drdy_to;

  assign saddr   = bus.SADDR;
  assign last    = (idx_q == IW'(NUM_REG - 1));
  assign drdy_to = (cnt_q == TW'(DRDY_TIMEOUT - 1));

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      daddr_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      di_q       <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      daddr_q    <= daddr_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      di_q       <= di_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    daddr_d    = daddr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    di_d       = di_q;
    bad_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.SEN) begin
          if (32'(saddr) < NUM_CFG) begin
            state_d    = S_ASSERT;
            idx_d      = '0;
            rom_addr_d = AW'(saddr) * AW'(NUM_REG);
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_ASSERT: state_d = S_FETCH;
      S_FETCH: begin
        daddr_d = bus.ROM_DATA[38:32];
        mask_d  = bus.ROM_DATA[31:16];
        data_d  = bus.ROM_DATA[15:0];
        state_d = S_READ;
      end
      S_READ: begin
        cnt_d   = '0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (bus.DRDY) begin
          di_d    = (bus.DO & mask_q) | data_q;
          state_d = S_WRITE;
        end else if (drdy_to) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        cnt_d   = '0;
        state_d = S_WAIT_WR;
        // Advance the ROM address early so data is ready in FETCH
        if (!last) rom_addr_d = rom_addr_q + 1'b1;
      end
      S_WAIT_WR: begin
        if (bus.DRDY) begin
          if (last) begin
            state_d = S_RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (drdy_to) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_d   = '0;
        state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (bus.LOCKED) begin
          state_d = S_DONE;
        end else if (cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.SRDY     = (state_q == S_DONE);
  assign bus.ERR      = (state_q == S_ABORT) | bad_q;
  assign bus.DEN      = (state_q == S_READ) | (state_q == S_WRITE);
  assign bus.DWE      = (state_q == S_WRITE);
  assign bus.MMCM_RST = (state_q == S_ASSERT)  | (state_q == S_FETCH) |
                        (state_q == S_READ)    | (state_q == S_WAIT_RD) |
                        (state_q == S_WRITE)   | (state_q == S_WAIT_WR);
  assign bus.ROM_ADDR = rom_addr_q;
  assign bus.DADDR    = daddr_q;
  assign bus.DI       = di_q;
endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: ROM, DRP and MMCM lock models with
// a read-modify-write reference and latency arithmetic.
module tb_mmcm_drp_reconfig;
  localparam int NC = 3;
  localparam int NR = 3;
  localparam int DT = 8;
  localparam int LT = 16;
  localparam int CW = 2;
  localparam int AW = 4;

  logic DCLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 DCLK = ~DCLK;

  mmcm_drp_reconfig_if #(.CW(CW), .AW(AW)) bus();

  mmcm_drp_reconfig #(
    .NUM_CFG(NC), .NUM_REG(NR),
    .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
  ) dut (
    .DCLK(DCLK), .RST_N(RST_N), .bus(bus)
  );

  logic [38:0] rom [16];
  logic [15:0] mem [128];
  logic [15:0] mem_init [128];
  logic load = 1'b0;
  logic spur = 1'b0;
  logic hold0 = 1'b0;
  logic drdy_m = 1'b0;
  logic lk = 1'b0;
  int maxlat = 1;
  int drop_den = 0;
  int den_n = 0;
  int pend = 0;
  int lat_sum = 0;
  int lock_d = 0;
  int lc = 0;

  always @(posedge DCLK) bus.ROM_DATA <= rom[bus.ROM_ADDR];

  // DRP slave: DRDY 1..maxlat cycles after DEN, optionally withheld
  always @(posedge DCLK) begin
    drdy_m <= 1'b0;
    if (pend > 1) pend <= pend - 1;
    else if (pend == 1) begin
      pend <= 0;
      drdy_m <= 1'b1;
    end
    if (load) mem <= mem_init;
    else if (bus.DEN) begin
      den_n <= den_n + 1;
      bus.DO <= mem[bus.DADDR];
      if (bus.DWE) mem[bus.DADDR] <= bus.DI;
      if (den_n + 1 != drop_den) begin
        automatic int l = $urandom_range(maxlat, 1);
        lat_sum <= lat_sum + l;
        if (l == 1) drdy_m <= 1'b1;
        else pend <= l - 1;
      end
    end
  end

  always @(posedge DCLK) begin
    if (bus.MMCM_RST) begin
      lk <= 1'b0;
      lc <= 0;
    end else if (lc >= lock_d) lk <= 1'b1;
    else lc <= lc + 1;
  end

  assign bus.LOCKED = lk & ~hold0;
  assign bus.DRDY = drdy_m | spur;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int proto_bad = 0;
  int t_busy, t_rel, busy_n, rises;
  logic busy_p = 1'b0;
  logic rst_p = 1'b0;
  int srdy_t[$];
  int err_t[$];
  int den_t[$];
  logic err_rst[$];
  logic [AW-1:0] rd_addr[$];
  logic [15:0] wr_di[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge DCLK);
    cyc++;
    if (bus.BUSY && !busy_p) begin
      t_busy = cyc;
      rises++;
    end
    if (bus.BUSY) busy_n++;
    if (!bus.MMCM_RST && rst_p) t_rel = cyc;
    if (bus.SRDY) srdy_t.push_back(cyc);
    if (bus.ERR) begin
      err_t.push_back(cyc);
      err_rst.push_back(bus.MMCM_RST);
    end
    if (bus.DEN) begin
      den_t.push_back(cyc);
      if (!bus.DWE) rd_addr.push_back(bus.ROM_ADDR);
      else wr_di.push_back(bus.DI);
    end
    if ((bus.DEN && !bus.MMCM_RST) || (bus.DWE && !bus.DEN) ||
        (bus.MMCM_RST && !bus.BUSY) ||
        32'(bus.ROM_ADDR) > NC * NR - 1)
      proto_bad++;
    busy_p = bus.BUSY;
    rst_p = bus.MMCM_RST;
  endtask

  task automatic clear();
    srdy_t.delete(); err_t.delete(); den_t.delete();
    err_rst.delete(); rd_addr.delete(); wr_di.delete();
    t_busy = -1; t_rel = -1; busy_n = 0; rises = 0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic run(input int sa, input bit spam, output int t0);
    bit ok;
    clear();
    ok = 1'b0;
    t0 = cyc;
    bus.SEN = 1'b1;
    bus.SADDR = CW'(sa);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!spam) bus.SEN = 1'b0;
      if (srdy_t.size() + err_t.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (spam) tick();
    bus.SEN = 1'b0;
    tick();
    tick();
    chk("run_finished", ok, 1);
  endtask

  typedef struct {
    int cfg;
    logic [15:0] init;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[5];
  logic [15:0] cur [4];
  logic [15:0] edi [3];
  logic [6:0] a;
  logic [15:0] m, d;
  int t0, l0, cf, wpos;

  initial begin
    vt[0] = '{1, 16'hFFFF, 16'h1000, 16'h0041, 16'h1041};
    vt[1] = '{0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    vt[2] = '{2, 16'hABCD, 16'h0000, 16'h1234, 16'h1234};
    vt[3] = '{1, 16'hABCD, 16'hFF00, 16'h0012, 16'hAB12};
    vt[4] = '{0, 16'h5A5A, 16'h0F0F, 16'hA0A0, 16'hAAAA};
    bus.SEN = 1'b0;
    bus.SADDR = '0;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < 128; i++) mem_init[i] = '0;
    clear();
    tick();
    tick();
    chk("reset_outputs",
        {bus.BUSY, bus.SRDY, bus.ERR, bus.DEN, bus.DWE,
         bus.MMCM_RST, bus.ROM_ADDR, bus.DADDR, bus.DI}, 0);
    RST_N = 1'b1;
    do_load();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NR; i++) begin
        a = 7'(16 + vt[v].cfg * NR + i);
        rom[vt[v].cfg * NR + i] = {a, vt[v].mask, vt[v].data};
        mem_init[a] = vt[v].init;
      end
      do_load();
      run(vt[v].cfg, 1'b0, t0);
      chk("vec_srdy_count", srdy_t.size(), 1);
      chk("vec_err_count", err_t.size(), 0);
      chk("vec_busy_at_accept", t_busy, t0 + 1);
      if (srdy_t.size() == 1)
        chk("vec_srdy_cycle", srdy_t[0] - t_busy, 18);
      chk("vec_rst_span", t_rel - t_busy, 1 + 5 * NR);
      chk("vec_write_count", wr_di.size(), NR);
      for (int i = 0; i < NR; i++) begin
        if (i < rd_addr.size())
          chk("vec_rom_addr", rd_addr[i], vt[v].cfg * NR + i);
        if (i < wr_di.size()) chk("vec_di", wr_di[i], vt[v].exp);
        chk("vec_mem", mem[16 + vt[v].cfg * NR + i], vt[v].exp);
      end
    end

    clear();
    t0 = cyc;
    bus.SEN = 1'b1;
    bus.SADDR = 2'd3;
    tick();
    bus.SEN = 1'b0;
    repeat (4) tick();
    chk("bad_err_count", err_t.size(), 1);
    if (err_t.size() == 1) chk("bad_err_cycle", err_t[0], t0 + 1);
    chk("bad_busy_cycles", busy_n, 0);
    chk("bad_den_count", den_t.size(), 0);

    maxlat = 1;
    drop_den = den_n + 3;
    run(1, 1'b0, t0);
    drop_den = 0;
    chk("drdy_to_err", err_t.size(), 1);
    chk("drdy_to_srdy", srdy_t.size(), 0);
    chk("drdy_to_dens", den_t.size(), 3);
    if (err_t.size() == 1 && den_t.size() == 3) begin
      chk("drdy_to_delay", err_t[0] - den_t[2], 9);
      chk("drdy_to_rst", err_rst[0], 0);
    end
    chk("drdy_to_idle", bus.BUSY, 0);

    hold0 = 1'b1;
    run(0, 1'b0, t0);
    hold0 = 1'b0;
    chk("lock_to_err", err_t.size(), 1);
    chk("lock_to_srdy", srdy_t.size(), 0);
    if (err_t.size() == 1) begin
      chk("lock_to_delay", err_t[0] - t_rel, LT + 1);
      chk("lock_to_rst", err_rst[0], 0);
    end
    run(2, 1'b0, t0);
    chk("lock_retry_srdy", srdy_t.size(), 1);
    chk("lock_retry_err", err_t.size(), 0);

    run(0, 1'b1, t0);
    repeat (20) tick();
    chk("spam_srdy_count", srdy_t.size(), 1);
    chk("spam_busy_rises", rises, 1);
    chk("spam_idle", bus.BUSY, 0);
    clear();
    spur = 1'b1;
    repeat (5) tick();
    spur = 1'b0;
    tick();
    chk("spur_dens", den_t.size(), 0);
    chk("spur_busy", busy_n, 0);
    chk("spur_err", err_t.size(), 0);

    for (int it = 0; it < 6; it++) begin
      cf = $urandom_range(NC - 1, 0);
      maxlat = 5;
      lock_d = $urandom_range(10, 0);
      for (int i = 0; i < NC * NR; i++)
        rom[i] = {7'(40 + $urandom_range(3, 0)),
                  16'($urandom), 16'($urandom)};
      for (int i = 0; i < 4; i++) begin
        cur[i] = 16'($urandom);
        mem_init[40 + i] = cur[i];
      end
      for (int i = 0; i < NR; i++) begin
        {a, m, d} = rom[cf * NR + i];
        edi[i] = (cur[a - 40] & m) | d;
        cur[a - 40] = edi[i];
      end
      do_load();
      l0 = lat_sum;
      run(cf, 1'b0, t0);
      chk("rnd_srdy_count", srdy_t.size(), 1);
      chk("rnd_err_count", err_t.size(), 0);
      if (srdy_t.size() == 1)
        chk("rnd_srdy_cycle", srdy_t[0] - t_busy,
            3 + 3 * NR + (lat_sum - l0) + lock_d);
      chk("rnd_write_count", wr_di.size(), NR);
      for (int i = 0; i < NR; i++)
        if (i < wr_di.size()) chk("rnd_di", wr_di[i], edi[i]);
      for (int i = 0; i < 4; i++) chk("rnd_mem", mem[40 + i], cur[i]);
    end
    maxlat = 1;
    lock_d = 0;

    clear();
    bus.SEN = 1'b1;
    bus.SADDR = 2'd1;
    tick();
    bus.SEN = 1'b0;
    wpos = 0;
    for (int k = 0; k < 60 && wpos == 0; k++) begin
      tick();
      if (wr_di.size() > 0) wpos = 1;
    end
    chk("arst_reached_write", wpos, 1);
    tick();
    chk("arst_in_wait_wr", {bus.BUSY, bus.MMCM_RST, bus.DEN}, 3'b110);
    #2 RST_N = 1'b0;
    #1 chk("arst_outputs",
           {bus.BUSY, bus.SRDY, bus.ERR, bus.DEN, bus.DWE,
            bus.MMCM_RST, bus.ROM_ADDR, bus.DADDR, bus.DI}, 0);
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    chk("arst_no_events", srdy_t.size() + err_t.size(), 0);
    run(0, 1'b0, t0);
    chk("arst_after_srdy", srdy_t.size(), 1);
    if (srdy_t.size() == 1)
      chk("arst_after_cycle", srdy_t[0] - t_busy, 18);

    chk("protocol_violations", proto_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
